ex_wb_stage: RTL and testbench
==============================

Name: ex_wb_stage

Overview:
- Stage directly downstream of the EX-stage control decoder. Consumes its decoded controls (enhilo, regsel, regwrite, rdrt, GPIO_OUT, GPIO_IN) together with ALU/multiplier results.
- Owns the HI/LO registers, the GPIO output latch and the GPIO input capture.
- Registers the EX→WB boundary and produces the register-file write port (data, address, enable) for WB.

Parameters:
- DW, 32, datapath width
- AW, 5, register address width
- SYNC_STAGES, 2, GPIO input synchroniser depth when GPIO_SYNC_EN is defined (allowed range 2..3)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-low; state resets on a clk edge while rst==0
- stall_EX  in  1  hold: the EX instruction does not retire this cycle
- flush_EX  in  1  kill the EX instruction
- alu_res_EX  in  DW  ALU result (low half of the product for mult/multu)
- alu_hi_EX  in  DW  high half of the product
- rt_data_EX  in  DW  rt read data; the GPIO write source
- rd_addr_EX  in  AW  instr[15:11]
- rt_addr_EX  in  AW  instr[20:16]
- enhilo_EX  in  1  write HI/LO
- regsel_EX  in  2  0=ALU, 1=HI, 2=LO, 3=reserved (treated as ALU)
- regwrite_EX  in  1  register write request
- rdrt_EX  in  1  1 selects rt as destination, 0 selects rd
- gpio_out_en_EX  in  1  GPIO write
- gpio_in_en_EX  in  1  GPIO read
- gpio_in  in  DW  asynchronous input pins
- gpio_out  out  DW  GPIO output latch
- hi_q  out  DW  HI register
- lo_q  out  DW  LO register
- writedata_WB  out  DW  register-file write data
- regdest_WB  out  AW  register-file write address
- regwrite_WB  out  1  register-file write enable

Behaviour:
- Reset (rst==0 at a clk edge): all outputs and internal flops go to 0, including synchroniser stages. Reset mid-operation discards the in-flight instruction; nothing partially retires.
- Retire condition: retire = ~stall_EX & ~flush_EX. On a non-retire cycle:
  - the WB register loads a bubble (regwrite_WB=0; data and dest hold their previous values);
  - HI, LO and gpio_out hold.
- HI/LO update: on a retiring edge with enhilo_EX=1, hi_q<=alu_hi_EX and lo_q<=alu_res_EX.
  - Update is one cycle, committed at the EX edge. An mfhi/mflo in the very next EX cycle sees the new value with no forwarding and no stall.
- Write-data select (registered into WB, latency 1):
  - gpio_in_en_EX=1: data = synchronised gpio_in. This overrides regsel and forces a write: regwrite_WB=1, dest=rd_addr_EX. This decode pairs gpio_in_en with regwrite=0 and regsel=1; the override is intentional.
  - else regsel=1: data = hi_q.
  - else regsel=2: data = lo_q.
  - else: data = alu_res_EX.
  - Same-cycle mult plus mfhi cannot occur (one instruction per EX cycle). The mfhi path reads the registered hi_q, never alu_hi_EX.
- Destination: regdest = rdrt_EX ? rt_addr_EX : rd_addr_EX.
- Register-zero suppression: regwrite_WB = 0 whenever the destination is 0, including the GPIO-read override.
- GPIO write: on a retiring edge with gpio_out_en_EX=1, gpio_out <= rt_data_EX. The register write for that instruction still follows regwrite_EX/regsel as decoded.
- Conflicting controls: gpio_in_en_EX and gpio_out_en_EX both 1 is illegal. The block performs both actions (latch the output, write the input data) and flags an assertion in simulation.
- Simultaneous stall and flush: treated as flush (bubble, no side effects).
- gpio_in is sampled every cycle regardless of stall.

Optional Feature:
- GPIO_SYNC_EN defined: gpio_in passes through a SYNC_STAGES-deep flop chain. Read latency from pin to captured value is SYNC_STAGES cycles plus the WB register.
- GPIO_SYNC_EN undefined: a single input register (one cycle) feeds the mux.

Decomposition:
- Package ctrl_pkg holds:
  - regsel encoding constants REGSEL_ALU=2'd0, REGSEL_HI=2'd1, REGSEL_LO=2'd2;
  - typedef ex_wb_t, a packed struct of {writedata, regdest, regwrite};
  - DW/AW defaults.
- One sub-module: gpio_in_sync (parameter depth, synchronous active-low reset). It is used for both the synchronised and the single-register build variants.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with arbitrary inputs → every output is 0. Release, then issue add with rd=5, alu_res=0x0000_0007 → next cycle writedata_WB=7, regdest_WB=5, regwrite_WB=1.
2. mult then mfhi/mflo back-to-back:
   - cycle0: enhilo=1, alu_hi=0x1, alu_res=0xFFFF_FFFE.
   - cycle1: regsel=1, rd=3 → WB cycle2: writedata=0x1, dest=3.
   - cycle2: regsel=2, rd=4 → WB: 0xFFFF_FFFE, dest=4.
3. Stall/flush: mult with stall_EX=1 → hi_q/lo_q unchanged and regwrite_WB=0. Same with flush_EX=1. Deassert both → update occurs on that edge.
4. GPIO write: gpio_out_en=1, rt_data=0xA5A5_0F0F → gpio_out=0xA5A5_0F0F after one edge and held through 10 subsequent non-GPIO instructions.
5. GPIO read (GPIO_SYNC_EN, SYNC_STAGES=2):
   - drive gpio_in=0x1234_5678, wait 2 cycles, issue gpio_in_en=1 with regwrite=0, regsel=1, rd=9 → writedata=0x1234_5678, dest=9, regwrite_WB=1.
   - repeat with rd=0 → regwrite_WB=0.
6. I-type destination: rdrt=1, rt=12, rd=7, alu_res=0x10 → regdest_WB=12. Add with rd=0 → regwrite_WB=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared EX/WB encodings, widths and the WB boundary record
// Used by ex_wb_stage (GPIO_SYNC_EN selects the synchronised GPIO input build).
package ctrl_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;

  localparam logic [1:0] REGSEL_ALU = 2'd0;
  localparam logic [1:0] REGSEL_HI  = 2'd1;
  localparam logic [1:0] REGSEL_LO  = 2'd2;

  typedef struct packed {
    logic [DW_DEF-1:0] writedata;
    logic [AW_DEF-1:0] regdest;
    logic              regwrite;
  } ex_wb_t;

  // A GPIO read always targets rd, whatever rdrt says.
  function automatic logic [AW_DEF-1:0] sel_dest(
    input logic              gpio_rd,
    input logic              rdrt,
    input logic [AW_DEF-1:0] rt_addr,
    input logic [AW_DEF-1:0] rd_addr
  );
    if (gpio_rd) begin
      return rd_addr;
    end
    return rdrt ? rt_addr : rd_addr;
  endfunction

endpackage

// File: rtl/gpio_in_sync.sv
// rtl/gpio_in_sync.sv - DEPTH-deep flop chain capturing the GPIO input pins
// DEPTH=1 gives the plain input register; DEPTH>=2 acts as a synchroniser.
module gpio_in_sync #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/ex_wb_stage.sv
// rtl/ex_wb_stage.sv - EX->WB boundary: HI/LO, GPIO latch/capture, regfile write port
// Build option: GPIO_SYNC_EN inserts a SYNC_STAGES-deep synchroniser on gpio_in.
module ex_wb_stage
  import ctrl_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int AW          = AW_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_EX,
  input  logic          flush_EX,
  input  logic [DW-1:0] alu_res_EX,
  input  logic [DW-1:0] alu_hi_EX,
  input  logic [DW-1:0] rt_data_EX,
  input  logic [AW-1:0] rd_addr_EX,
  input  logic [AW-1:0] rt_addr_EX,
  input  logic          enhilo_EX,
  input  logic [1:0]    regsel_EX,
  input  logic          regwrite_EX,
  input  logic          rdrt_EX,
  input  logic          gpio_out_en_EX,
  input  logic          gpio_in_en_EX,
  input  logic [DW-1:0] gpio_in,
  output logic [DW-1:0] gpio_out,
  output logic [DW-1:0] hi_q,
  output logic [DW-1:0] lo_q,
  output logic [DW-1:0] writedata_WB,
  output logic [AW-1:0] regdest_WB,
  output logic          regwrite_WB
);

`ifdef GPIO_SYNC_EN
  localparam int CAP_DEPTH = SYNC_STAGES;
`else
  localparam int CAP_DEPTH = 1;
`endif

  logic [DW-1:0] gpio_cap;
  logic [DW-1:0] hi_d, lo_d, gpio_out_d;
  logic [AW-1:0] dest;
  logic          retire;
  ex_wb_t        wb_d, wb_q;

  gpio_in_sync #(
    .DW    (DW),
    .DEPTH (CAP_DEPTH)
  ) u_gpio_in_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (gpio_in),
    .q_o    (gpio_cap)
  );

  // Stall and flush together resolve to a plain bubble with no side effects.
  assign retire = ~stall_EX & ~flush_EX;
  assign dest   = sel_dest(gpio_in_en_EX, rdrt_EX, rt_addr_EX, rd_addr_EX);

  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    gpio_out_d  = gpio_out;
    wb_d        = wb_q;
    wb_d.regwrite = 1'b0;
    if (retire) begin
      if (enhilo_EX) begin
        hi_d = alu_hi_EX;
        lo_d = alu_res_EX;
      end
      if (gpio_out_en_EX) begin
        gpio_out_d = rt_data_EX;
      end
      // mfhi/mflo read the committed registers, never the in-flight product.
      if (gpio_in_en_EX) begin
        wb_d.writedata = gpio_cap;
      end else begin
        case (regsel_EX)
          REGSEL_HI: wb_d.writedata = hi_q;
          REGSEL_LO: wb_d.writedata = lo_q;
          default:   wb_d.writedata = alu_res_EX;
        endcase
      end
      wb_d.regdest  = dest;
      wb_d.regwrite = (regwrite_EX | gpio_in_en_EX) & (|dest);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q     <= '0;
      lo_q     <= '0;
      gpio_out <= '0;
      wb_q     <= '0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      gpio_out <= gpio_out_d;
      wb_q     <= wb_d;
    end
  end

  assign writedata_WB = wb_q.writedata;
  assign regdest_WB   = wb_q.regdest;
  assign regwrite_WB  = wb_q.regwrite;

  // GPIO read and write in one instruction is an illegal decode.
  a_gpio_rw_exclusive : assert property (@(posedge clk) disable iff (!rst)
    !(gpio_in_en_EX && gpio_out_en_EX));

endmodule

// File: tb/tb_ex_wb_stage.sv
// tb/tb_ex_wb_stage.sv - self-checking bench for ex_wb_stage
module tb_ex_wb_stage;

`ifdef GPIO_SYNC_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush, enhilo, regwrite, rdrt, gout, gin;
  logic [1:0]  regsel;
  logic [4:0]  rd, rt;
  logic [31:0] alu, ahi, rtd, pin;
  logic [31:0] gpio_out, hi_q, lo_q, wd;
  logic [4:0]  dest;
  logic        we;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_hi, m_lo, m_gout, m_wd;
  logic [4:0]  m_dest;
  logic        m_we;
  logic [31:0] pin_hist [3];

  always #5 clk = ~clk;

  ex_wb_stage #(.DW(32), .AW(5), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .stall_EX(stall), .flush_EX(flush),
    .alu_res_EX(alu), .alu_hi_EX(ahi), .rt_data_EX(rtd),
    .rd_addr_EX(rd), .rt_addr_EX(rt), .enhilo_EX(enhilo),
    .regsel_EX(regsel), .regwrite_EX(regwrite), .rdrt_EX(rdrt),
    .gpio_out_en_EX(gout), .gpio_in_en_EX(gin), .gpio_in(pin),
    .gpio_out(gpio_out), .hi_q(hi_q), .lo_q(lo_q),
    .writedata_WB(wd), .regdest_WB(dest), .regwrite_WB(we)
  );

  // ctl = {rst, stall, flush, enhilo, regsel[1:0], regwrite, rdrt, gout, gin}
  typedef struct {
    logic [9:0]  ctl;
    logic [4:0]  rd, rt;
    logic [31:0] alu, ahi, rtd, pin;
    logic [31:0] e_wd;
    logic [4:0]  e_dest;
    logic        e_we;
    logic [31:0] e_hi, e_lo, e_gout;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The model is updated from the inputs present just before each edge.
  task automatic model_edge();
    logic [31:0] cap, data;
    logic [4:0]  d;
    if (!rst) begin
      m_hi = 0; m_lo = 0; m_gout = 0; m_wd = 0; m_dest = 0; m_we = 0;
      for (int i = 0; i < 3; i++) pin_hist[i] = 0;
    end else begin
      cap = pin_hist[DEPTH-1];
      if (!stall && !flush) begin
        d = gin ? rd : (rdrt ? rt : rd);
        if (gin) data = cap;
        else if (regsel == 2'd1) data = m_hi;
        else if (regsel == 2'd2) data = m_lo;
        else data = alu;
        m_wd = data;
        m_dest = d;
        m_we = (gin || regwrite) && (d != 0);
        if (enhilo) begin m_hi = ahi; m_lo = alu; end
        if (gout) m_gout = rtd;
      end else begin
        m_we = 0;
      end
      pin_hist[2] = pin_hist[1];
      pin_hist[1] = pin_hist[0];
      pin_hist[0] = pin;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    {rst, stall, flush, enhilo, regsel, regwrite, rdrt, gout, gin} = v.ctl;
    rd = v.rd; rt = v.rt; alu = v.alu; ahi = v.ahi; rtd = v.rtd; pin = v.pin;
  endtask

  task automatic nop();
    stall = 0; flush = 0; enhilo = 0; regsel = 0; regwrite = 0; rdrt = 0;
    gout = 0; gin = 0; rd = 0; rt = 0; alu = 0; ahi = 0; rtd = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".wd"},   wd,              m_wd);
    chk({tag, ".dest"}, {27'd0, dest},   {27'd0, m_dest});
    chk({tag, ".we"},   {31'd0, we},     {31'd0, m_we});
    chk({tag, ".hi"},   hi_q,            m_hi);
    chk({tag, ".lo"},   lo_q,            m_lo);
    chk({tag, ".gout"}, gpio_out,        m_gout);
  endtask

  initial begin
    rst = 0; nop(); pin = 0;

    vecs[0]  = '{10'b0_0_0_1_00_1_0_1_0, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h1111, 32'hFFFF, 32'h1357, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0};
    vecs[1]  = vecs[0];
    vecs[2]  = vecs[0];
    vecs[3]  = '{10'b1_0_0_0_00_1_0_0_0, 5'd5, 5'd0, 32'h7, 32'h0, 32'h0, 32'h0, 32'h7, 5'd5, 1'b1, 32'h0, 32'h0, 32'h0};
    vecs[4]  = '{10'b1_0_0_1_00_0_0_0_0, 5'd0, 5'd0, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h0, 32'hFFFF_FFFE, 5'd0, 1'b0, 32'h1, 32'hFFFF_FFFE, 32'h0};
    vecs[5]  = '{10'b1_0_0_0_01_1_0_0_0, 5'd3, 5'd0, 32'h99, 32'h77, 32'h0, 32'h0, 32'h1, 5'd3, 1'b1, 32'h1, 32'hFFFF_FFFE, 32'h0};
    vecs[6]  = '{10'b1_0_0_0_10_1_0_0_0, 5'd4, 5'd0, 32'h99, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFE, 5'd4, 1'b1, 32'h1, 32'hFFFF_FFFE, 32'h0};
    vecs[7]  = '{10'b1_1_0_1_00_1_0_1_0, 5'd8, 5'd0, 32'h66, 32'h55, 32'hBAD, 32'h0, 32'hFFFF_FFFE, 5'd4, 1'b0, 32'h1, 32'hFFFF_FFFE, 32'h0};
    vecs[8]  = '{10'b1_0_1_1_00_1_0_1_0, 5'd8, 5'd0, 32'h66, 32'h55, 32'hBAD, 32'h0, 32'hFFFF_FFFE, 5'd4, 1'b0, 32'h1, 32'hFFFF_FFFE, 32'h0};
    vecs[9]  = '{10'b1_1_1_1_00_1_0_1_0, 5'd8, 5'd0, 32'h66, 32'h55, 32'hBAD, 32'h0, 32'hFFFF_FFFE, 5'd4, 1'b0, 32'h1, 32'hFFFF_FFFE, 32'h0};
    vecs[10] = '{10'b1_0_0_1_00_1_0_0_0, 5'd8, 5'd0, 32'h66, 32'h55, 32'h0, 32'h0, 32'h66, 5'd8, 1'b1, 32'h55, 32'h66, 32'h0};
    vecs[11] = '{10'b1_0_0_0_00_1_1_0_0, 5'd7, 5'd12, 32'h10, 32'h0, 32'h0, 32'h0, 32'h10, 5'd12, 1'b1, 32'h55, 32'h66, 32'h0};
    vecs[12] = '{10'b1_0_0_0_00_1_0_0_0, 5'd0, 5'd0, 32'h20, 32'h0, 32'h0, 32'h0, 32'h20, 5'd0, 1'b0, 32'h55, 32'h66, 32'h0};
    vecs[13] = '{10'b1_0_0_0_11_1_0_0_0, 5'd2, 5'd0, 32'h30, 32'h0, 32'h0, 32'h0, 32'h30, 5'd2, 1'b1, 32'h55, 32'h66, 32'h0};

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i]);
      step();
      chk($sformatf("vec%0d.wd", i),   wd,            vecs[i].e_wd);
      chk($sformatf("vec%0d.dest", i), {27'd0, dest}, {27'd0, vecs[i].e_dest});
      chk($sformatf("vec%0d.we", i),   {31'd0, we},   {31'd0, vecs[i].e_we});
      chk($sformatf("vec%0d.hi", i),   hi_q,          vecs[i].e_hi);
      chk($sformatf("vec%0d.lo", i),   lo_q,          vecs[i].e_lo);
      chk($sformatf("vec%0d.gout", i), gpio_out,      vecs[i].e_gout);
    end

    // GPIO write, then held across ten non-GPIO instructions
    nop(); gout = 1; rtd = 32'hA5A5_0F0F; regwrite = 1; alu = 32'h44; rd = 5'd6;
    step();
    chk("gpio_wr.gout", gpio_out, 32'hA5A5_0F0F);
    chk("gpio_wr.wd", wd, 32'h44);
    chk("gpio_wr.we", {31'd0, we}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      nop(); regwrite = 1'($urandom); alu = $urandom; rtd = $urandom;
      rd = 5'($urandom); regsel = 2'($urandom); enhilo = 1'($urandom);
      step();
      chk($sformatf("gpio_hold%0d", i), gpio_out, 32'hA5A5_0F0F);
    end

    // GPIO read: override of regwrite=0/regsel=1, r0 suppression, capture latency
    nop(); pin = 32'h1234_5678;
    repeat (3) step();
    gin = 1; regwrite = 0; regsel = 2'd1; rd = 5'd9;
    step();
    chk("gpio_rd.wd", wd, 32'h1234_5678);
    chk("gpio_rd.dest", {27'd0, dest}, 32'd9);
    chk("gpio_rd.we", {31'd0, we}, 32'd1);
    rd = 5'd0;
    step();
    chk("gpio_rd_r0.we", {31'd0, we}, 32'd0);
    pin = 32'hCAFE_0001; rd = 5'd10;
    step();
    chk("gpio_rd_lat.wd", wd, 32'h1234_5678);
    nop();
    step();

    // Reset mid-operation retires nothing
    nop(); rst = 0; enhilo = 1; ahi = 32'h9; alu = 32'h8; gout = 1; rtd = 32'h77;
    regwrite = 1; rd = 5'd3;
    step();
    chk("midrst.hi", hi_q, 32'h0);
    chk("midrst.lo", lo_q, 32'h0);
    chk("midrst.gout", gpio_out, 32'h0);
    chk("midrst.we", {31'd0, we}, 32'd0);
    chk("midrst.wd", wd, 32'h0);
    rst = 1;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 31) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      enhilo = 1'($urandom); regsel = 2'($urandom); regwrite = 1'($urandom);
      rdrt = 1'($urandom);
      gin = ($urandom_range(0, 3) == 0);
      gout = gin ? 1'b0 : ($urandom_range(0, 3) == 0);
      rd = 5'($urandom); rt = 5'($urandom);
      alu = $urandom; ahi = $urandom; rtd = $urandom; pin = $urandom;
      step();
      chk_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
